uart_tx_buffered: RTL

- Buffered 8N1 UART transmitter; the transmit counterpart to the bootloader's UART receiver.
- Accepts bytes from core logic over a valid/ready handshake into a small FIFO.
- Serialises bytes LSB-first onto ftdi_tx at a fixed clocks-per-bit rate.
- Sits in top between the bootloader command logic and the FTDI TX pin (status/echo/ack path back to the host).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx_buffered.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned CLKS_PER_BIT_115200_12MHZ = 104;
    localparam int unsigned DATA_BITS                 = 8;
    localparam logic        IDLE_LEVEL                = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; dout is combinational from the read pointer.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       hwclk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap by power-of-two width) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge hwclk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter (LSB first, idle high).
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200_12MHZ,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       hwclk,
    input  logic       resetn,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        serial_q, serial_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        bit_end;

    assign o_tx_ready  = !fifo_full;
    assign fifo_push   = i_tx_valid && !fifo_full;
    assign bit_end     = (baud_q == BAUD_LAST);
    assign o_tx_serial = serial_q;
    assign o_tx_busy   = busy_q;
    assign o_tx_done   = done_q;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .hwclk (hwclk),
        .resetn(resetn),
        .push  (fifo_push),
        .din   (i_tx_byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, baud/bit counters, shifter and registered line outputs.
    // Outputs are computed from current state so the line lags state by one cycle.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_q;
`endif
            default: serial_d = IDLE_LEVEL;
        endcase

        done_d = (state_q == STOP) && bit_end;
        busy_d = (state_q != IDLE) || !fifo_empty;
    end

    // State and output registers; reset drives the line high immediately.
    always_ff @(posedge hwclk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= IDLE_LEVEL;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
